keypad_scanner: RTL and testbench

Scanning controller for the 4x3 (12-key) matrix keypad. It is the driving end of the Row/Col interface used by the virtual keypad model.
- Drives one column high at a time and samples the four row lines.
- Builds a 12-bit key map per full scan, debounces it, and reports one debounced key code per press to the lock control logic.
- Key index = row*3 + col, matching the keypad model's Key[11:0] numbering.

---
 rtl/keypad_pkg.sv | 50 +++++
 rtl/keypad_col_driver.sv | 59 +++++
 rtl/keypad_scanner.sv | 198 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x3 matrix keypad scanner.
`default_nettype none

package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 3;
    localparam int NUM_KEYS = 12;

    typedef logic [3:0] key_code_t;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        SINGLE = 2'd1,
        MULTI  = 2'd2
    } scan_class_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } state_t;

    typedef struct packed {
        scan_class_t cls;
        key_code_t   idx;
    } scan_result_t;

    // idx is only meaningful when cls == SINGLE
    function automatic scan_result_t classify(input logic [NUM_KEYS-1:0] map);
        scan_result_t res;
        int unsigned  cnt;
        cnt     = 0;
        res.idx = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (map[i]) begin
                cnt++;
                res.idx = key_code_t'(i);
            end
        end
        if (cnt == 0)      res.cls = NONE;
        else if (cnt == 1) res.cls = SINGLE;
        else               res.cls = MULTI;
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_col_driver.sv
// Column ring for the keypad scanner: dwell counter, one-hot column drive,
// row sample strobe and end-of-scan strobe.
`default_nettype none

module keypad_col_driver
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 16
) (
    input  logic                clock_i,
    input  logic                reset_ni,
    output logic [NUM_COLS-1:0] col_o,
    output logic                sample_en_o,
    output logic [1:0]          col_idx_o,
    output logic                scan_done_o
);

    localparam int             DWELL_W    = $clog2(SCAN_DIV);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);

    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [1:0]         col_idx_q, col_idx_d;
    logic               w_sample;

    always_comb begin
        w_sample  = (dwell_q == DWELL_LAST);
        dwell_d   = dwell_q + 1'b1;
        col_idx_d = col_idx_q;
        if (w_sample) begin
            dwell_d   = '0;
            col_idx_d = (col_idx_q == 2'd2) ? 2'd0 : col_idx_q + 2'd1;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            dwell_q   <= '0;
            col_idx_q <= 2'd0;
        end else begin
            dwell_q   <= dwell_d;
            col_idx_q <= col_idx_d;
        end
    end

    always_comb begin
        case (col_idx_q)
            2'd1:    col_o = 3'b010;
            2'd2:    col_o = 3'b100;
            default: col_o = 3'b001;
        endcase
    end

    assign sample_en_o = w_sample;
    assign col_idx_o   = col_idx_q;
    assign scan_done_o = w_sample && (col_idx_q == 2'd2);

endmodule

`default_nettype wire

// File: rtl/keypad_scanner.sv
// 4x3 keypad scanner: key map, scan classification, debounce FSM.
// Define KEYPAD_REPEAT_EN to add auto-repeat of the held key.
`default_nettype none

module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 16,
    parameter int DEBOUNCE_CNT = 4,
    parameter int REPEAT_DELAY = 32,
    parameter int REPEAT_RATE  = 8
) (
    input  logic                clock_i,
    input  logic                reset_ni,
    input  logic [NUM_ROWS-1:0] row_i,
    output logic [NUM_COLS-1:0] col_o,
    output key_code_t           key_code_o,
    output logic                key_valid_o,
    output logic                key_held_o,
    output logic                multi_key_o
);

    localparam int                DCNT_W  = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DCNT_W-1:0] DB_LAST = DCNT_W'(DEBOUNCE_CNT - 1);
    localparam logic [DCNT_W-1:0] DB_ONE  = DCNT_W'(1);

    logic                w_sample_en;
    logic                w_scan_done;
    logic [1:0]          w_col_idx;
    logic [NUM_KEYS-1:0] map_q, map_d;
    scan_result_t        w_scan;
    logic                w_same;
    logic                w_enter_held;
    logic                w_rep_pulse;

    state_t              state_q, state_d;
    key_code_t           cand_q, cand_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    key_code_t           key_code_q, key_code_d;
    logic                held_q, held_d;
    logic                valid_q, valid_d;
    logic                multi_q, multi_d;

    keypad_col_driver #(
        .SCAN_DIV (SCAN_DIV)
    ) u_col_driver (
        .clock_i     (clock_i),
        .reset_ni    (reset_ni),
        .col_o       (col_o),
        .sample_en_o (w_sample_en),
        .col_idx_o   (w_col_idx),
        .scan_done_o (w_scan_done)
    );

    // Classification uses map_d so the last column's sample is included
    always_comb begin
        map_d = map_q;
        if (w_sample_en) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                map_d[r * NUM_COLS + int'(w_col_idx)] = row_i[r];
            end
        end
        w_scan = classify(map_d);
        w_same = (w_scan.idx == cand_q);
    end

    always_comb begin
        state_d      = state_q;
        cand_d       = cand_q;
        dcnt_d       = dcnt_q;
        key_code_d   = key_code_q;
        held_d       = held_q;
        multi_d      = multi_q;
        w_enter_held = 1'b0;
        if (w_scan_done) begin
            multi_d = (w_scan.cls == MULTI);
            case (state_q)
                IDLE: begin
                    if (w_scan.cls == SINGLE) begin
                        cand_d = w_scan.idx;
                        dcnt_d = DB_ONE;
                        if (DEBOUNCE_CNT == 1) w_enter_held = 1'b1;
                        else                   state_d      = PRESS_DB;
                    end
                end
                PRESS_DB: begin
                    if (w_scan.cls == SINGLE) begin
                        if (!w_same) begin
                            cand_d = w_scan.idx;
                            dcnt_d = DB_ONE;
                        end else if (dcnt_q >= DB_LAST) begin
                            w_enter_held = 1'b1;
                        end else begin
                            dcnt_d = dcnt_q + 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                        dcnt_d  = '0;
                    end
                end
                HELD: begin
                    if (w_scan.cls == NONE) begin
                        dcnt_d = DB_ONE;
                        if (DEBOUNCE_CNT == 1) begin
                            state_d = IDLE;
                            held_d  = 1'b0;
                            dcnt_d  = '0;
                        end else begin
                            state_d = REL_DB;
                        end
                    end
                end
                default: begin
                    if (w_scan.cls != NONE) begin
                        state_d = HELD;
                        dcnt_d  = '0;
                    end else if (dcnt_q >= DB_LAST) begin
                        state_d = IDLE;
                        held_d  = 1'b0;
                        dcnt_d  = '0;
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
            endcase
            if (w_enter_held) begin
                state_d    = HELD;
                key_code_d = cand_d;
                held_d     = 1'b1;
                dcnt_d     = '0;
            end
        end
        valid_d = w_enter_held | w_rep_pulse;
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            map_q      <= '0;
            state_q    <= IDLE;
            cand_q     <= '0;
            dcnt_q     <= '0;
            key_code_q <= '0;
            held_q     <= 1'b0;
            valid_q    <= 1'b0;
            multi_q    <= 1'b0;
        end else begin
            map_q      <= map_d;
            state_q    <= state_d;
            cand_q     <= cand_d;
            dcnt_q     <= dcnt_d;
            key_code_q <= key_code_d;
            held_q     <= held_d;
            valid_q    <= valid_d;
            multi_q    <= multi_d;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int                RCNT_W     = $clog2(REPEAT_DELAY + 1);
    localparam logic [RCNT_W-1:0] REP_LAST   = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] REP_RELOAD = RCNT_W'(REPEAT_DELAY - REPEAT_RATE);

    logic [RCNT_W-1:0] rcnt_q, rcnt_d;

    // Reloading to DELAY-RATE makes every later repeat land RATE scans apart
    always_comb begin
        rcnt_d      = rcnt_q;
        w_rep_pulse = 1'b0;
        if (state_q != HELD) begin
            rcnt_d = '0;
        end else if (w_scan_done && (w_scan.cls == SINGLE) && w_same) begin
            if (rcnt_q >= REP_LAST) begin
                w_rep_pulse = 1'b1;
                rcnt_d      = REP_RELOAD;
            end else begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) rcnt_q <= '0;
        else           rcnt_q <= rcnt_d;
    end
`else
    assign w_rep_pulse = 1'b0;
    if (REPEAT_DELAY < 0 || REPEAT_RATE < 0) begin : g_repeat_unused
    end
`endif

    assign key_code_o  = key_code_q;
    assign key_valid_o = valid_q;
    assign key_held_o  = held_q;
    assign multi_key_o = multi_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a key-pulse scoreboard.
`default_nettype none

module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int SCAN = 12;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] keys  = '0;
    logic [3:0]  row;
    logic [2:0]  col;
    key_code_t   code;
    logic        valid, held, multi;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [3:0] code;
        int         at;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    always_comb begin
        for (int r = 0; r < 4; r++) row[r] = |(keys[r*3 +: 3] & col);
    end

    keypad_scanner #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (3),
        .REPEAT_DELAY (5),
        .REPEAT_RATE  (2)
    ) dut (
        .clock_i     (clk),
        .reset_ni    (rst_n),
        .row_i       (row),
        .col_o       (col),
        .key_code_o  (code),
        .key_valid_o (valid),
        .key_held_o  (held),
        .multi_key_o (multi)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_pulse(input logic [3:0] c, input int at);
        exp_t e;
        e.code = c;
        e.at   = at;
        sb.push_back(e);
    endtask

    task automatic check_pulse();
        exp_t e;
        if (valid === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL pulse_unexpected observed=code%0d@%0d expected=none", code, cyc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                assert (code === e.code && cyc == e.at) else begin
                    failures++;
                    $error("FAIL pulse observed=code%0d@%0d expected=code%0d@%0d",
                           code, cyc, e.code, e.at);
                end
            end
        end else if (sb.size() != 0 && cyc > sb[0].at) begin
            e = sb.pop_front();
            checks++;
            assert (cyc <= e.at) else begin
                failures++;
                $error("FAIL pulse_missing observed=none@%0d expected=code%0d@%0d", cyc, e.code, e.at);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            check_pulse();
        end
    endtask

    initial begin
        int acc;
        // 1: reset and column ring
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        chk("rst_col", col, 3'b001);
        chk("rst_code", code, 0);
        chk("rst_valid", valid, 0);
        chk("rst_held", held, 0);
        chk("rst_multi", multi, 0);
        tick(3);  chk("ring_c3", col, 3'b001);
        tick(1);  chk("ring_c4", col, 3'b010);
        tick(4);  chk("ring_c8", col, 3'b100);
        tick(4);  chk("ring_c12", col, 3'b001);

        // 2: steady Key5
        keys = 12'(1 << 5);
        acc  = cyc + 3 * SCAN;
        expect_pulse(4'd5, acc);
`ifdef KEYPAD_REPEAT_EN
        for (int s = 5; acc + s * SCAN <= acc + 20 * SCAN - 1; s += 2) expect_pulse(4'd5, acc + s * SCAN);
`endif
        tick(3 * SCAN);
        chk("k5_held", held, 1);
        chk("k5_code", code, 5);
        tick(20 * SCAN);

        // 4: release, re-press, short release
        keys = '0;
        tick(2 * SCAN); chk("rel2_held", held, 1);
        tick(SCAN);     chk("rel3_held", held, 0);
        chk("rel_code_kept", code, 5);
        keys = 12'(1 << 5);
        expect_pulse(4'd5, cyc + 3 * SCAN);
        tick(3 * SCAN); chk("repress_held", held, 1);
        keys = '0;
        tick(2 * SCAN);
        keys = 12'(1 << 5);
        tick(3 * SCAN); chk("bounce_held", held, 1);
        keys = '0;
        tick(3 * SCAN); chk("k5_off_held", held, 0);

        // 3: toggled Key7 then stable
        for (int i = 0; i < 4; i++) begin
            keys = (i % 2 == 0) ? 12'(1 << 7) : 12'h000;
            tick(SCAN);
        end
        keys = 12'(1 << 7);
        expect_pulse(4'd7, cyc + 3 * SCAN);
        tick(3 * SCAN);
        chk("k7_held", held, 1);
        chk("k7_code", code, 7);
        keys = '0;
        tick(3 * SCAN); chk("k7_off_held", held, 0);

        // 5: multi-key
        keys = 12'h801;
        tick(SCAN);
        chk("multi_idle", multi, 1);
        chk("multi_idle_held", held, 0);
        tick(2 * SCAN);
        keys = 12'(1 << 4);
        expect_pulse(4'd4, cyc + 3 * SCAN);
        tick(SCAN);     chk("multi_clear", multi, 0);
        tick(2 * SCAN); chk("k4_held", held, 1);
        keys = keys | 12'(1 << 9);
        tick(SCAN);
        chk("ghost_multi", multi, 1);
        chk("ghost_code", code, 4);
        chk("ghost_held", held, 1);
        tick(2 * SCAN);
        keys = '0;
        tick(3 * SCAN);
        chk("k4_off_held", held, 0);
        chk("k4_off_multi", multi, 0);

        // 6: reset during press debounce
        keys = 12'(1 << 2);
        tick(2 * SCAN + 3);
        rst_n = 1'b0;
        #1;
        chk("arst_col", col, 3'b001);
        chk("arst_code", code, 0);
        chk("arst_held", held, 0);
        chk("arst_valid", valid, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        acc   = 3 * SCAN;
        expect_pulse(4'd2, acc);
`ifdef KEYPAD_REPEAT_EN
        expect_pulse(4'd2, acc + 5 * SCAN);
        expect_pulse(4'd2, acc + 7 * SCAN);
        expect_pulse(4'd2, acc + 9 * SCAN);
`endif
        tick(2 * SCAN); chk("post_rst_not_held", held, 0);
        tick(SCAN);
        chk("post_rst_held", held, 1);
        chk("post_rst_code", code, 2);
        tick(10 * SCAN);
        keys = '0;
        tick(3 * SCAN);
        chk("k2_off_held", held, 0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
